seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 139 +++++++++++++
 tb/tb_seg_scan.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan -- four-digit multiplexed seven-segment scanner.
//
// A prescaler divides the clock into digit slots of REFRESH_DIV cycles. Each
// slot opens with DEAD cycles of all anodes off (ghosting guard), then shows
// the selected nibble of a shadow register that is loaded on demand.
//
// Parameters
//   REFRESH_DIV  cycles per digit slot (>= 4)
//   DEAD         all-off cycles at the start of each slot (0 .. REFRESH_DIV-2)
//   BLINK_DIV    cycles per blink half-period (used with SEG_SCAN_BLINK_EN)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   digits[15:0] four BCD nibbles, [3:0] is digit 0 (rightmost)
//   load         captures digits into the shadow register at the next edge
//   blank[3:0]   bit n suppresses digit n
//   blink_mask   bit n makes digit n blink (only with SEG_SCAN_BLINK_EN)
//   digit_val    nibble for the downstream decoder, 4'hF = blank
//   an[3:0]      active-low anode enables, bit n drives digit n
//   scan_tick    one-cycle pulse in the cycle after each digit advance
//
// Optional feature macro: SEG_SCAN_BLINK_EN adds the blink_mask port, a blink
// counter and a blink phase. Without it the display behaves as phase 0.
//
// Timing: digit_val/an are computed from the next-state prescaler, select and
// shadow values, so the registered outputs line up with the prescaler value
// they belong to. A load coinciding with an advance is therefore visible in
// the first visible cycle of the new digit, and with DEAD=0 the new digit
// appears in the cycle right after the advance.
// ---------------------------------------------------------------------------
module seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD        = 16,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        load,
    input  logic [3:0]  blank,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic [3:0]  digit_val,
    output logic [3:0]  an,
    output logic        scan_tick
);

    localparam int            PW     = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD_V = PW'(DEAD);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    dv_q, dv_d;
    logic          tick_q;
    logic          adv;
    logic          in_dead;
    logic          blink_hide;
    logic          hide;

    always_comb begin
        adv      = (presc_q == LAST);
        presc_d  = adv ? '0 : presc_q + 1'b1;
        sel_d    = adv ? sel_q + 2'd1 : sel_q;
        shadow_d = load ? digits : shadow_q;
    end

    // Dead-time test on the prescaler value the outputs will accompany.
    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (presc_d < DEAD_V);
        end
    endgenerate

`ifdef SEG_SCAN_BLINK_EN
    localparam int            BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          blink_wrap;

    always_comb begin
        blink_wrap  = (blink_cnt_q == BLAST);
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        phase_d     = phase_q ^ blink_wrap;
        blink_hide  = phase_d & blink_mask[sel_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    assign blink_hide = 1'b0;
`endif

    // At most one anode is ever driven low: either all off, or one-hot-low.
    always_comb begin
        hide = in_dead | blank[sel_d] | blink_hide;
        an_d = hide ? 4'hF : ~(4'b0001 << sel_d);
        dv_d = hide ? 4'hF : 4'(shadow_d >> {sel_d, 2'b00});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            sel_q    <= 2'd0;
            shadow_q <= 16'h0000;
            an_q     <= 4'hF;
            dv_q     <= 4'hF;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            dv_q     <= dv_d;
            tick_q   <= adv;
        end
    end

    assign an        = an_q;
    assign digit_val = dv_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan with REFRESH_DIV=8, DEAD=2, BLINK_DIV=32.
// Timeline: k counts clock edges since the last reset edge. At k the
// prescaler is k%8, the selected digit is (k/8)%4, and positions 0..1 of each
// slot are dead time. All inputs change and outputs are read 1 ns after an edge.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  digit_val;
  logic [3:0]  an;
  logic        scan_tick;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  seg_scan #(.REFRESH_DIV(8), .DEAD(2), .BLINK_DIV(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .digits    (digits),
    .load      (load),
    .blank     (blank),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .digit_val (digit_val),
    .an        (an),
    .scan_tick (scan_tick)
  );

  // clock block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    step();
    step();
    rst = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (an !== 4'hF) begin n_err++; $display("FAIL reset_an got=%h exp=f", an); end
    n_cmp++;
    if (digit_val !== 4'hF) begin n_err++; $display("FAIL reset_dv got=%h exp=f", digit_val); end
    n_cmp++;
    if (scan_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", scan_tick); end
  endtask

  // Free run with shadow at zero: tick every 8, anode order 0,1,2,3,0.
  task automatic test_free_run();
    logic [3:0] e_an, e_dv;
    logic       e_tick;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      e_an   = (k % 8 < 2) ? 4'hF : ~(4'b0001 << ((k / 8) % 4));
      e_dv   = (k % 8 < 2) ? 4'hF : 4'h0;
      e_tick = (k > 0) && (k % 8 == 0);
      n_cmp++;
      if (an !== e_an) begin n_err++; $display("FAIL run_an k=%0d got=%b exp=%b", k, an, e_an); end
      n_cmp++;
      if (digit_val !== e_dv) begin n_err++; $display("FAIL run_dv k=%0d got=%h exp=%h", k, digit_val, e_dv); end
      n_cmp++;
      if (scan_tick !== e_tick) begin n_err++; $display("FAIL run_tick k=%0d got=%b exp=%b", k, scan_tick, e_tick); end
      step();
    end
  endtask

  // Load 1234 once, then change digits without load: display keeps 1234.
  task automatic test_load();
    logic [15:0] exp_sh;
    logic [3:0]  e_an, e_dv;
    int          s;
    exp_sh = 16'h1234;
    do_reset();
    digits = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    digits = 16'h9999;
    for (int i = 0; i < 32; i++) begin
      s    = (k / 8) % 4;
      e_an = (k % 8 < 2) ? 4'hF : ~(4'b0001 << s);
      e_dv = (k % 8 < 2) ? 4'hF : 4'((exp_sh >> (4 * s)) & 16'hF);
      n_cmp++;
      if (an !== e_an) begin n_err++; $display("FAIL load_an k=%0d got=%b exp=%b", k, an, e_an); end
      n_cmp++;
      if (digit_val !== e_dv) begin n_err++; $display("FAIL load_dv k=%0d got=%h exp=%h", k, digit_val, e_dv); end
      step();
    end
  endtask

  // Digit 2 blanked for its whole slot, the others unaffected.
  task automatic test_blank();
    logic [15:0] exp_sh;
    logic [3:0]  e_an, e_dv;
    int          s;
    exp_sh = 16'h1234;
    do_reset();
    blank = 4'b0100;
    digits = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 32; i++) begin
      s = (k / 8) % 4;
      if ((k % 8 < 2) || s == 2) begin
        e_an = 4'hF;
        e_dv = 4'hF;
      end else begin
        e_an = ~(4'b0001 << s);
        e_dv = 4'((exp_sh >> (4 * s)) & 16'hF);
      end
      n_cmp++;
      if (an !== e_an) begin n_err++; $display("FAIL blank_an k=%0d got=%b exp=%b", k, an, e_an); end
      n_cmp++;
      if (digit_val !== e_dv) begin n_err++; $display("FAIL blank_dv k=%0d got=%h exp=%h", k, digit_val, e_dv); end
      step();
    end
    blank = 4'h0;
  endtask

  // Load during the advance cycle into digit 1; nibble A passes through.
  task automatic test_load_at_advance();
    do_reset();
    digits = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    while (k < 7) step();
    n_cmp++;
    if (digit_val !== 4'h4) begin n_err++; $display("FAIL adv_pre_dv got=%h exp=4", digit_val); end
    digits = 16'h00A0;
    load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (scan_tick !== 1'b1) begin n_err++; $display("FAIL adv_tick got=%b exp=1", scan_tick); end
    n_cmp++;
    if (an !== 4'hF) begin n_err++; $display("FAIL adv_dead_an got=%b exp=1111", an); end
    step();
    step();
    n_cmp++;
    if (an !== 4'b1101) begin n_err++; $display("FAIL adv_vis_an got=%b exp=1101", an); end
    n_cmp++;
    if (digit_val !== 4'hA) begin n_err++; $display("FAIL adv_vis_dv got=%h exp=a", digit_val); end
  endtask

  // Reset mid-slot: anodes off at the next edge, then restart at digit 0.
  task automatic test_reset_mid();
    do_reset();
    digits = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    while (k < 12) step();
    n_cmp++;
    if (an !== 4'b1101 || digit_val !== 4'h3) begin
      n_err++; $display("FAIL mid_pre got=%b/%h exp=1101/3", an, digit_val);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (an !== 4'hF || digit_val !== 4'hF) begin
      n_err++; $display("FAIL mid_rst got=%b/%h exp=1111/f", an, digit_val);
    end
    rst = 1'b0;
    k = 0;
    step();
    n_cmp++;
    if (an !== 4'hF) begin n_err++; $display("FAIL mid_k1_an got=%b exp=1111", an); end
    step();
    n_cmp++;
    if (an !== 4'b1110 || digit_val !== 4'h0) begin
      n_err++; $display("FAIL mid_k2 got=%b/%h exp=1110/0", an, digit_val);
    end
    while (k < 8) begin
      n_cmp++;
      if (scan_tick !== 1'b0) begin n_err++; $display("FAIL mid_notick k=%0d got=%b exp=0", k, scan_tick); end
      step();
    end
    n_cmp++;
    if (scan_tick !== 1'b1) begin n_err++; $display("FAIL mid_tick got=%b exp=1", scan_tick); end
  endtask

`ifdef SEG_SCAN_BLINK_EN
  // Digit 0 visible during blink phase 0 (k/32 even), blank during phase 1.
  task automatic test_blink();
    logic [3:0] e_an;
    int         s;
    do_reset();
    blink_mask = 4'b0001;
    for (int i = 0; i < 128; i++) begin
      s = (k / 8) % 4;
      if ((k % 8 < 2) || (s == 0 && ((k / 32) % 2) == 1)) e_an = 4'hF;
      else e_an = ~(4'b0001 << s);
      n_cmp++;
      if (an !== e_an) begin n_err++; $display("FAIL blink_an k=%0d got=%b exp=%b", k, an, e_an); end
      step();
    end
    blink_mask = 4'h0;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_load();
    test_blank();
    test_load_at_advance();
    test_reset_mid();
`ifdef SEG_SCAN_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
